// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard unit for a five-stage pipeline (Fetch, Decode, Execute, Memory,
// Writeback). It drives the Execute operand forwarding selects, the
// pipeline-register stalls and the bubble (flush) inserts. It also runs a
// small FSM that covers multi-cycle data-memory waits and the extra
// Decode flush that follows a taken branch.
//
// Configuration macro: HAZARD_FORWARDING_EN
//   defined   : ForwardAE/ForwardBE select M- or W-stage results, and only
//               loads in Execute cause a load-use stall.
//   undefined : ForwardAE/ForwardBE are tied to 00, and every RAW match of a
//               Decode source against a writing E or M stage (register 15
//               excluded) stalls like a load-use hazard.
//
// Ports
//   CLK                    clock, all state changes on its rising edge
//   RESET                  asynchronous, active-low reset
//   Ra1D, Ra2D             Decode source registers
//   Ra1E, Ra2E             Execute source registers
//   WA3E, WA3M, WA3W       destination registers in Execute, Memory, Writeback
//   RegWriteE/M/W          register write enables per stage
//   MemtoRegE              Execute holds a load
//   BranchTakenE           taken branch / PC write resolved in Execute
//   MemReqM, MemReady      data-memory access pending in Memory / completion
//   ForwardAE, ForwardBE   00 = register file, 01 = ResultW, 10 = ALUResultM
//   StallF/D/E/M           pipeline register holds
//   FlushD, FlushE         bubble inserts into Decode / Execute
//   StateOut               RUN = 00, MEMWAIT = 01, BRFLUSH = 10
// ---------------------------------------------------------------------------
module hazard_ctrl (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] Ra1D,
    input  logic [3:0] Ra2D,
    input  logic [3:0] Ra1E,
    input  logic [3:0] Ra2E,
    input  logic [3:0] WA3E,
    input  logic [3:0] WA3M,
    input  logic [3:0] WA3W,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       BranchTakenE,
    input  logic       MemReqM,
    input  logic       MemReady,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] StateOut
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        BRFLUSH = 2'b10
    } stateT;

    stateT state;
    stateT nextState;
    logic branchPending;
    logic nextBranchPending;

    logic [1:0] forwardA;
    logic [1:0] forwardB;
    logic loadUse;
    logic memStall;
    logic stallFc, stallDc, stallEc, stallMc, flushDc, flushEc;

    logic matchE;
    logic matchM;

    // Decode sources that the instructions in Execute / Memory will write.
    assign matchE = (WA3E == Ra1D) || (WA3E == Ra2D);
    assign matchM = (WA3M == Ra1D) || (WA3M == Ra2D);

    assign memStall = MemReqM && !MemReady;

`ifdef HAZARD_FORWARDING_EN
    // Operand selects for Execute: the Memory-stage result is newer than
    // the Writeback result, so it wins when both match. R15 is the PC and
    // is never forwarded.
    always_comb begin
        forwardA = 2'b00;
        forwardB = 2'b00;
        if (RegWriteM && (WA3M == Ra1E) && (WA3M != 4'd15))
            forwardA = 2'b10;
        else if (RegWriteW && (WA3W == Ra1E) && (WA3W != 4'd15))
            forwardA = 2'b01;
        if (RegWriteM && (WA3M == Ra2E) && (WA3M != 4'd15))
            forwardB = 2'b10;
        else if (RegWriteW && (WA3W == Ra2E) && (WA3W != 4'd15))
            forwardB = 2'b01;
    end

    // With forwarding, only a load in Execute is too late to forward.
    assign loadUse = MemtoRegE && matchE;
`else
    assign forwardA = 2'b00;
    assign forwardB = 2'b00;

    // Without forwarding, any pending write to a Decode source must drain
    // before Decode may read the register file.
    assign loadUse = (MemtoRegE && matchE)
                   || (RegWriteE && (WA3E != 4'd15) && matchE)
                   || (RegWriteM && (WA3M != 4'd15) && matchM);

    logic unusedFwdInputs;
    assign unusedFwdInputs = ^{Ra1E, Ra2E, WA3W, RegWriteW};
`endif

    // State register. branchPending remembers a taken branch that was
    // blocked by a memory wait, so it is acted on once after release even
    // though the branch has left Execute by then.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= RUN;
            branchPending <= 1'b0;
        end else begin
            state         <= nextState;
            branchPending <= nextBranchPending;
        end
    end

    // Next state and stall/flush generation. Priority in RUN is memory
    // stall, then branch, then load-use; a load-use coincident with a
    // branch is dropped because the Decode instruction is squashed.
    always_comb begin
        nextState         = state;
        nextBranchPending = branchPending;
        stallFc           = 1'b0;
        stallDc           = 1'b0;
        stallEc           = 1'b0;
        stallMc           = 1'b0;
        flushDc           = 1'b0;
        flushEc           = 1'b0;
        case (state)
            RUN: begin
                if (memStall) begin
                    {stallFc, stallDc, stallEc, stallMc} = 4'b1111;
                    nextState = MEMWAIT;
                    if (BranchTakenE)
                        nextBranchPending = 1'b1;
                end else if (BranchTakenE || branchPending) begin
                    flushDc           = 1'b1;
                    flushEc           = 1'b1;
                    nextState         = BRFLUSH;
                    nextBranchPending = 1'b0;
                end else if (loadUse) begin
                    stallFc = 1'b1;
                    stallDc = 1'b1;
                    flushEc = 1'b1;
                end
            end
            MEMWAIT: begin
                if (BranchTakenE)
                    nextBranchPending = 1'b1;
                if (MemReady)
                    nextState = RUN;
                else
                    {stallFc, stallDc, stallEc, stallMc} = 4'b1111;
            end
            BRFLUSH: begin
                // A memory wait here still bubbles Decode (wrong-path
                // instruction) while holding everything else.
                if (memStall) begin
                    stallFc = 1'b1;
                    stallEc = 1'b1;
                    stallMc = 1'b1;
                    flushDc = 1'b1;
                    nextState = MEMWAIT;
                    if (BranchTakenE)
                        nextBranchPending = 1'b1;
                end else if (BranchTakenE) begin
                    flushDc           = 1'b1;
                    flushEc           = 1'b1;
                    nextBranchPending = 1'b0;
                end else begin
                    flushDc   = 1'b1;
                    nextState = RUN;
                end
            end
            default: begin
                nextState         = RUN;
                nextBranchPending = 1'b0;
            end
        endcase
    end

    // Outputs are forced to their idle values while RESET is low, without
    // waiting for a clock edge.
    assign ForwardAE = RESET ? forwardA : 2'b00;
    assign ForwardBE = RESET ? forwardB : 2'b00;
    assign StallF    = RESET & stallFc;
    assign StallD    = RESET & stallDc;
    assign StallE    = RESET & stallEc;
    assign StallM    = RESET & stallMc;
    assign FlushD    = RESET & flushDc;
    assign FlushE    = RESET & flushEc;
    assign StateOut  = RESET ? state : 2'b00;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl. Single-cycle vectors come from a
// table; multi-cycle behaviour (memory wait, branch flush, reset abandon)
// is covered by short hand-written sequences. Expected results are queued
// when stimulus is driven and compared when outputs are sampled mid-cycle.
// Honours HAZARD_FORWARDING_EN so the same bench covers both builds.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] Ra1D, Ra2D, Ra1E, Ra2E, WA3E, WA3M, WA3W;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
    logic       BranchTakenE, MemReqM, MemReady;
    logic [1:0] ForwardAE, ForwardBE, StateOut;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE;

    typedef struct {
        string      name;
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       rwE, rwM, rwW, m2rE, br, memReq, memRdy;
        logic [11:0] exp;
    } vecT;

    vecT tbl[$];
    vecT sb[$];
    int compared = 0;
    int mismatched = 0;

    hazard_ctrl dut (
        .CLK(CLK), .RESET(RESET),
        .Ra1D(Ra1D), .Ra2D(Ra2D), .Ra1E(Ra1E), .Ra2E(Ra2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE),
        .MemReqM(MemReqM), .MemReady(MemReady),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .StateOut(StateOut)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected-output packing: {fwdA, fwdB, sF, sD, sE, sM, fD, fE, state}
    function automatic logic [11:0] ex(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic sF, input logic sD, input logic sE,
                                       input logic sM, input logic fD, input logic fE,
                                       input logic [1:0] st);
        return {fa, fb, sF, sD, sE, sM, fD, fE, st};
    endfunction

    // Quiet vector: all register numbers distinct so nothing matches.
    function automatic vecT idle(input string n);
        vecT v;
        v.name = n;
        v.ra1d = 4'd1; v.ra2d = 4'd2; v.ra1e = 4'd3; v.ra2e = 4'd4;
        v.wa3e = 4'd6; v.wa3m = 4'd7; v.wa3w = 4'd8;
        v.rwE = 1'b0; v.rwM = 1'b0; v.rwW = 1'b0; v.m2rE = 1'b0;
        v.br = 1'b0; v.memReq = 1'b0; v.memRdy = 1'b0;
        v.exp = 12'h000;
        return v;
    endfunction

    task automatic applyStimulus(input vecT v);
        Ra1D = v.ra1d; Ra2D = v.ra2d; Ra1E = v.ra1e; Ra2E = v.ra2e;
        WA3E = v.wa3e; WA3M = v.wa3m; WA3W = v.wa3w;
        RegWriteE = v.rwE; RegWriteM = v.rwM; RegWriteW = v.rwW;
        MemtoRegE = v.m2rE; BranchTakenE = v.br;
        MemReqM = v.memReq; MemReady = v.memRdy;
        sb.push_back(v);
    endtask

    task automatic checkOutput(input bit waitEdge);
        vecT e;
        logic [11:0] act;
        if (waitEdge) @(negedge CLK);
        else #1;
        act = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, StateOut};
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_empty: got %h required an entry", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.exp) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h required %h (fa fb sF sD sE sM fD fE st)",
                         e.name, act, e.exp);
            end
        end
    endtask

    task automatic cycle(input vecT v);
        @(posedge CLK);
        #1;
        applyStimulus(v);
        checkOutput(1'b1);
    endtask

    task automatic releaseReset(input vecT v);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        applyStimulus(v);
        checkOutput(1'b1);
    endtask

    initial begin
        vecT v;
        vecT act;
        vecT ms;

        // Single-cycle table, every entry starts and ends in RUN.
        v = idle("idle"); tbl.push_back(v);
        v = idle("fwdA_M_over_W");
        v.rwM = 1; v.wa3m = 4'd3; v.rwW = 1; v.wa3w = 4'd3; v.ra1e = 4'd3;
        v.exp = ex(FWD ? 2'b10 : 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00); tbl.push_back(v);
        v.name = "fwdA_W_only"; v.rwM = 0;
        v.exp = ex(FWD ? 2'b01 : 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00); tbl.push_back(v);
        v = idle("fwdB_M"); v.rwM = 1; v.wa3m = 4'd4;
        v.exp = ex(2'b00, FWD ? 2'b10 : 2'b00, 0, 0, 0, 0, 0, 0, 2'b00); tbl.push_back(v);
        v = idle("fwdB_W"); v.rwW = 1; v.wa3w = 4'd4;
        v.exp = ex(2'b00, FWD ? 2'b01 : 2'b00, 0, 0, 0, 0, 0, 0, 2'b00); tbl.push_back(v);
        v = idle("fwd_r15_excluded"); v.rwM = 1; v.wa3m = 4'd15; v.rwW = 1;
        v.wa3w = 4'd15; v.ra1e = 4'd15; v.ra2e = 4'd15; tbl.push_back(v);
        v = idle("loaduse_ra2d"); v.m2rE = 1; v.wa3e = 4'd5; v.ra2d = 4'd5;
        v.exp = ex(2'b00, 2'b00, 1, 1, 0, 0, 0, 1, 2'b00); tbl.push_back(v);
        v = idle("loaduse_cleared"); tbl.push_back(v);
        v = idle("loaduse_ra1d"); v.m2rE = 1; v.wa3e = 4'd1;
        v.exp = ex(2'b00, 2'b00, 1, 1, 0, 0, 0, 1, 2'b00); tbl.push_back(v);
        v = idle("load_no_match"); v.m2rE = 1; v.wa3e = 4'd5; tbl.push_back(v);
        v = idle("raw_E_alu"); v.rwE = 1; v.wa3e = 4'd2; v.ra1d = 4'd2;
        v.exp = ex(2'b00, 2'b00, !FWD, !FWD, 0, 0, 0, !FWD, 2'b00); tbl.push_back(v);
        v = idle("raw_M_alu"); v.rwM = 1; v.wa3m = 4'd2;
        v.exp = ex(2'b00, 2'b00, !FWD, !FWD, 0, 0, 0, !FWD, 2'b00); tbl.push_back(v);
        v = idle("raw_r15_excluded"); v.rwE = 1; v.wa3e = 4'd15; v.ra1d = 4'd15;
        tbl.push_back(v);

        // Reset with busy inputs: outputs must be idle regardless.
        act = idle("reset_busy_inputs");
        act.memReq = 1; act.br = 1; act.m2rE = 1; act.wa3e = 4'd1;
        act.rwM = 1; act.wa3m = 4'd3;
        RESET = 1'b0;
        #2;
        applyStimulus(act);
        checkOutput(1'b0);
        act.name = "reset_held_over_edge";
        cycle(act);
        releaseReset(idle("reset_release_idle"));

        foreach (tbl[i]) cycle(tbl[i]);

        // Memory wait: 3 not-ready cycles, then ready.
        ms = idle("mem_enter"); ms.memReq = 1;
        ms.exp = ex(2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 2'b00); cycle(ms);
        ms.name = "mem_wait1"; ms.exp = ex(2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 2'b01); cycle(ms);
        ms.name = "mem_wait2"; cycle(ms);
        v = ms; v.name = "mem_ready"; v.memRdy = 1;
        v.exp = ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01); cycle(v);
        cycle(idle("mem_back_to_run"));

        // Branch together with load-use.
        v = idle("br_loaduse_c1"); v.br = 1; v.m2rE = 1; v.wa3e = 4'd5; v.ra2d = 4'd5;
        v.exp = ex(2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 2'b00); cycle(v);
        v.name = "br_loaduse_c2"; v.br = 0;
        v.exp = ex(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 2'b10); cycle(v);
        cycle(idle("br_loaduse_c3"));

        // Branch again while in BRFLUSH.
        v = idle("br_again_c1"); v.br = 1;
        v.exp = ex(2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 2'b00); cycle(v);
        v.name = "br_again_c2"; v.exp = ex(2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 2'b10); cycle(v);
        v = idle("br_again_c3"); v.exp = ex(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 2'b10); cycle(v);
        cycle(idle("br_again_c4"));

        // Branch held during a memory wait is taken once after release.
        v = idle("br_in_mem_c1"); v.memReq = 1; v.br = 1;
        v.exp = ex(2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 2'b00); cycle(v);
        v.name = "br_in_mem_c2"; v.exp = ex(2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 2'b01); cycle(v);
        v.name = "br_in_mem_ready"; v.memRdy = 1;
        v.exp = ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01); cycle(v);
        v = idle("br_after_mem_c1"); v.exp = ex(2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 2'b00); cycle(v);
        v = idle("br_after_mem_c2"); v.exp = ex(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 2'b10); cycle(v);
        cycle(idle("br_after_mem_once"));

        // Reset in the middle of MEMWAIT.
        ms = idle("rst_mem_enter"); ms.memReq = 1;
        ms.exp = ex(2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 2'b00); cycle(ms);
        ms.name = "rst_mem_wait"; ms.exp = ex(2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 2'b01); cycle(ms);
        #2;
        RESET = 1'b0;
        v = ms; v.name = "rst_mem_async"; v.exp = 12'h000;
        applyStimulus(v);
        checkOutput(1'b0);
        v.name = "rst_mem_held"; cycle(v);
        ms.name = "rst_mem_fresh_eval"; ms.exp = ex(2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 2'b00);
        releaseReset(ms);
        ms.name = "rst_mem_reenter"; ms.exp = ex(2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 2'b01); cycle(ms);
        v = ms; v.name = "rst_mem_ready"; v.memRdy = 1;
        v.exp = ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01); cycle(v);
        cycle(idle("rst_mem_run"));

        // Reset in the middle of BRFLUSH.
        v = idle("rst_br_c1"); v.br = 1;
        v.exp = ex(2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 2'b00); cycle(v);
        v = idle("rst_br_c2"); v.exp = ex(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 2'b10); cycle(v);
        #2;
        RESET = 1'b0;
        v = idle("rst_br_async");
        applyStimulus(v);
        checkOutput(1'b0);
        releaseReset(idle("rst_br_released"));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
